// File: rtl/axis_frame_checker_if.sv
// AXI-Stream interface carrying one data stream from a master to a slave.
// Handshake: a beat transfers on a rising aclk edge where axis_tvalid and
// axis_tready are both high. The master holds tvalid/tdata/tlast stable until
// that transfer, and tready may be asserted regardless of tvalid.
interface axi_stream_inf #(
   parameter int DSIZE = 16,
   parameter int USIZE = 1
) (
   input logic aclk
);
   logic             aclken;
   logic             axis_tvalid;
   logic             axis_tready;
   logic [DSIZE-1:0] axis_tdata;
   logic             axis_tlast;
   logic [USIZE-1:0] axis_tuser;

   modport master (
      input  aclk, axis_tready,
      output aclken, axis_tvalid, axis_tdata, axis_tlast, axis_tuser
   );

   modport slave (
      input  aclk, aclken, axis_tvalid, axis_tdata, axis_tlast, axis_tuser,
      output axis_tready
   );
endinterface

// File: rtl/axis_frame_checker.sv
// Stream sink that checks each frame for an incrementing payload (0,1,2,..)
// and an expected beat count, with programmable back-pressure and registered
// frame/beat/error statistics. busy reflects the receive FSM state.
module axis_frame_checker #(
   parameter int DSIZE = 16,
   parameter int LSIZE = 16,
   parameter int CSIZE = 32
) (
   input  logic             clock,
   input  logic             rst_n,
   axi_stream_inf.slave     sink_inf,
   input  logic [3:0]       throttle,
   input  logic [LSIZE-1:0] exp_len,
   input  logic             clr,
   output logic [CSIZE-1:0] frame_cnt,
   output logic [CSIZE-1:0] beat_cnt,
   output logic [15:0]      err_cnt,
   output logic [LSIZE-1:0] last_len,
   output logic             err_data,
   output logic             err_len,
   output logic             busy
);
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   localparam logic [LSIZE-1:0] LEN_MAX = '1;

   state_t           state_q, state_d;
   logic             tready_q, tready_d;
   logic [3:0]       gap_q, gap_d;
   logic [DSIZE-1:0] exp_data_q, exp_data_d;
   logic [LSIZE-1:0] idx_q, idx_d;
   logic [CSIZE-1:0] frame_cnt_q, frame_cnt_d;
   logic [CSIZE-1:0] beat_cnt_q, beat_cnt_d;
   logic [15:0]      err_cnt_q, err_cnt_d;
   logic [LSIZE-1:0] last_len_q, last_len_d;
   logic             err_data_q, err_data_d;
   logic             err_len_q, err_len_d;

   logic             accept;
   logic [LSIZE-1:0] frame_len;
   logic [16:0]      err_sum;

   // tready comes straight from a flop, so it never depends on tvalid
   assign accept               = sink_inf.axis_tvalid & tready_q;
   assign sink_inf.axis_tready = tready_q;

   // Next-state, data/length checks, back-pressure gap and statistics
   always_comb begin
      state_d     = state_q;
      tready_d    = tready_q;
      gap_d       = gap_q;
      exp_data_d  = exp_data_q;
      idx_d       = idx_q;
      last_len_d  = last_len_q;
      err_data_d  = 1'b0;
      err_len_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      err_cnt_d   = err_cnt_q;

      // Length of the frame if the current beat is its last (saturating)
      frame_len = (idx_q == LEN_MAX) ? LEN_MAX : idx_q + LSIZE'(1);

      // Back-pressure: after an accept hold tready low for 'throttle' cycles
      if (accept && throttle != 4'd0) begin
         tready_d = 1'b0;
         gap_d    = throttle;
      end else if (!tready_q) begin
         if (gap_q > 4'd1) begin
            gap_d = gap_q - 4'd1;
         end else begin
            gap_d    = 4'd0;
            tready_d = 1'b1;
         end
      end

      if (accept) begin
         err_data_d = (sink_inf.axis_tdata != exp_data_q);
         beat_cnt_d = beat_cnt_q + CSIZE'(1);
         if (sink_inf.axis_tlast) begin
            state_d     = ST_IDLE;
            exp_data_d  = '0;
            idx_d       = '0;
            last_len_d  = frame_len;
            err_len_d   = (exp_len != '0) && (frame_len != exp_len);
            frame_cnt_d = frame_cnt_q + CSIZE'(1);
         end else begin
            state_d    = ST_RECV;
            // Equals expected+1 on a match; resyncs to received+1 on a miss
            exp_data_d = sink_inf.axis_tdata + DSIZE'(1);
            idx_d      = frame_len;
         end
      end

      err_sum   = {1'b0, err_cnt_q} + {16'd0, err_data_d} + {16'd0, err_len_d};
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

      // Clear wins over any increment in the same cycle
      if (clr) begin
         frame_cnt_d = '0;
         beat_cnt_d  = '0;
         err_cnt_d   = '0;
      end
   end

   // State and statistics registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tready_q    <= 1'b0;
         gap_q       <= 4'd0;
         exp_data_q  <= '0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         beat_cnt_q  <= '0;
         err_cnt_q   <= 16'd0;
         last_len_q  <= '0;
         err_data_q  <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tready_q    <= tready_d;
         gap_q       <= gap_d;
         exp_data_q  <= exp_data_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         err_cnt_q   <= err_cnt_d;
         last_len_q  <= last_len_d;
         err_data_q  <= err_data_d;
         err_len_q   <= err_len_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign beat_cnt  = beat_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign last_len  = last_len_q;
   assign err_data  = err_data_q;
   assign err_len   = err_len_q;
   assign busy      = (state_q == ST_RECV);
endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: directed scenarios plus randomized frames,
// compared every cycle against a frame-level model, with literal pins.
module tb_axis_frame_checker;
   localparam int D    = 16;
   localparam int L    = 4;   // narrow length field so saturation is reachable
   localparam int C    = 32;
   localparam int LMAX = (1 << L) - 1;

   // ---------------- clock / reset ----------------
   logic clock;
   logic rst_n;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [3:0]   throttle;
   logic [L-1:0] exp_len;
   logic         clr;
   logic [C-1:0] frame_cnt, beat_cnt;
   logic [15:0]  err_cnt;
   logic [L-1:0] last_len;
   logic         err_data, err_len, busy;

   axi_stream_inf #(.DSIZE(D), .USIZE(1)) sink_if (.aclk(clock));

   axis_frame_checker #(.DSIZE(D), .LSIZE(L), .CSIZE(C)) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .sink_inf (sink_if),
      .throttle (throttle),
      .exp_len  (exp_len),
      .clr      (clr),
      .frame_cnt(frame_cnt),
      .beat_cnt (beat_cnt),
      .err_cnt  (err_cnt),
      .last_len (last_len),
      .err_data (err_data),
      .err_len  (err_len),
      .busy     (busy)
   );

   int n_vec = 0;
   int n_err = 0;
   bit run   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          cyc;         // cycles since reset release
   int          next_ready;  // first cycle at which tready is high again
   bit          m_acc;
   logic [15:0] frame_q[$];  // beats of the frame in progress
   logic [31:0] e_frame, e_beat;
   int          e_err;
   int          e_last_len;
   bit          e_err_data, e_err_len, e_busy;
   logic [15:0] want;
   int          n_len;

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; next_ready = 1; m_acc = 1'b0;
         frame_q.delete();
         e_frame = 0; e_beat = 0; e_err = 0; e_last_len = 0;
         e_err_data = 1'b0; e_err_len = 1'b0; e_busy = 1'b0;
      end else begin
         m_acc = sink_if.axis_tvalid && (cyc >= next_ready);
         cyc++;
         e_err_data = 1'b0;
         e_err_len  = 1'b0;
         if (m_acc) begin
            want = (frame_q.size() == 0) ? 16'd0 : 16'(frame_q[$] + 16'd1);
            e_err_data = (sink_if.axis_tdata != want);
            frame_q.push_back(sink_if.axis_tdata);
            next_ready = cyc + int'(throttle);
            if (sink_if.axis_tlast) begin
               n_len = (frame_q.size() > LMAX) ? LMAX : frame_q.size();
               e_last_len = n_len;
               e_err_len  = (exp_len != 0) && (n_len != int'(exp_len));
               frame_q.delete();
            end
         end
         e_busy = (frame_q.size() != 0);
         if (clr) begin
            e_frame = 0; e_beat = 0; e_err = 0;
         end else begin
            if (m_acc) e_beat = e_beat + 1;
            if (m_acc && sink_if.axis_tlast) e_frame = e_frame + 1;
            e_err = e_err + int'(e_err_data) + int'(e_err_len);
            if (e_err > 65535) e_err = 65535;
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clock) begin
      if (run) begin
         check("tready",    {31'd0, sink_if.axis_tready}, {31'd0, (cyc >= next_ready)});
         check("frame_cnt", frame_cnt, e_frame);
         check("beat_cnt",  beat_cnt, e_beat);
         check("err_cnt",   {16'd0, err_cnt}, 32'(e_err));
         check("last_len",  {28'd0, last_len}, 32'(e_last_len));
         check("err_data",  {31'd0, err_data}, {31'd0, e_err_data});
         check("err_len",   {31'd0, err_len}, {31'd0, e_err_len});
         check("busy",      {31'd0, busy}, {31'd0, e_busy});
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic send_beat(input logic [15:0] d, input bit last, input bit c);
      int guard = 0;
      sink_if.axis_tvalid = 1'b1;
      sink_if.axis_tdata  = d;
      sink_if.axis_tlast  = last;
      clr = c;
      do begin
         @(negedge clock);
         guard++;
      end while (!m_acc && guard < 64);
      if (!m_acc) begin
         n_err++;
         $display("FAIL accept_timeout: no handshake after %0d cycles, want 1", guard);
      end
      clr = 1'b0;
   endtask

   task automatic idle(input int n);
      sink_if.axis_tvalid = 1'b0;
      sink_if.axis_tlast  = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clock);
      clr = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int flen;
      logic [15:0] d;
      rst_n = 1'b0;
      throttle = 4'd0; exp_len = '0; clr = 1'b0;
      sink_if.aclken = 1'b1; sink_if.axis_tuser = 1'b0;
      sink_if.axis_tvalid = 1'b0; sink_if.axis_tdata = '0; sink_if.axis_tlast = 1'b0;
      run = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_tready", {31'd0, sink_if.axis_tready}, 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clock);
      check("first_tready", {31'd0, sink_if.axis_tready}, 32'd1);

      // Clean 4-beat frame, always ready
      exp_len = 4'd4;
      for (int i = 0; i < 4; i++) send_beat(16'(i), i == 3, 1'b0);
      check("t1_frame", frame_cnt, 32'd1);
      check("t1_beat", beat_cnt, 32'd4);
      check("t1_last_len", {28'd0, last_len}, 32'd4);
      check("t1_err", {16'd0, err_cnt}, 32'd0);
      check("t1_model_beat", e_beat, 32'd4);
      idle(2);

      // Throttle 2 with tvalid held high
      do_clr();
      throttle = 4'd2; exp_len = 4'd3;
      for (int i = 0; i < 3; i++) send_beat(16'(i), i == 2, 1'b0);
      check("t2_tready_low", {31'd0, sink_if.axis_tready}, 32'd0);
      check("t2_busy_end", {31'd0, busy}, 32'd0);
      idle(4);

      // Data mismatch on beat 3
      do_clr();
      throttle = 4'd0; exp_len = 4'd4;
      send_beat(16'd0, 0, 0); send_beat(16'd1, 0, 0);
      send_beat(16'd7, 0, 0);
      check("t3_err_data", {31'd0, err_data}, 32'd1);
      send_beat(16'd8, 1, 0);
      check("t3_no_err_len", {31'd0, err_len}, 32'd0);
      check("t3_err_cnt", {16'd0, err_cnt}, 32'd1);
      idle(2);

      // Data and length errors: 0,5,2 with exp_len=5
      do_clr();
      exp_len = 4'd5;
      send_beat(16'd0, 0, 0); send_beat(16'd5, 0, 0); send_beat(16'd2, 1, 0);
      check("t4_err_len", {31'd0, err_len}, 32'd1);
      check("t4_err_cnt", {16'd0, err_cnt}, 32'd3);
      check("t4_model_err", 32'(e_err), 32'd3);
      check("t4_last_len", {28'd0, last_len}, 32'd3);
      idle(2);

      // Single-beat frame with clr, then without
      do_clr();
      exp_len = 4'd1;
      send_beat(16'd0, 1, 1);
      check("t5_frame_clr", frame_cnt, 32'd0);
      check("t5_last_len", {28'd0, last_len}, 32'd1);
      check("t5_busy", {31'd0, busy}, 32'd0);
      send_beat(16'd0, 1, 0);
      check("t5_frame", frame_cnt, 32'd1);
      idle(2);

      // Reset in the middle of a frame
      exp_len = 4'd2;
      send_beat(16'd0, 0, 0); send_beat(16'd1, 0, 0);
      idle(0);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clock);
      check("t6_rst_tready", {31'd0, sink_if.axis_tready}, 32'd0);
      check("t6_rst_beat", beat_cnt, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      #1 rst_n = 1'b1;
      @(negedge clock);
      send_beat(16'd0, 0, 0); send_beat(16'd1, 1, 0);
      check("t6_frame", frame_cnt, 32'd1);
      check("t6_err", {16'd0, err_cnt}, 32'd0);
      idle(2);

      // Long frame saturates the beat index
      exp_len = 4'd5;
      for (int i = 0; i < 20; i++) send_beat(16'(i), i == 19, 0);
      check("t7_last_len_sat", {28'd0, last_len}, 32'(LMAX));
      idle(2);

      // Randomized frames
      for (int f = 0; f < 60; f++) begin
         throttle = 4'($urandom_range(0, 3));
         exp_len  = 4'($urandom_range(0, 6));
         flen     = $urandom_range(1, 8);
         for (int i = 0; i < flen; i++) begin
            d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(i);
            send_beat(d, i == flen - 1, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
         idle($urandom_range(0, 2));
      end

      // Error counter saturation: two errors per single-beat frame
      do_clr();
      throttle = 4'd0; exp_len = 4'd2;
      for (int i = 0; i < 32767; i++) send_beat(16'd1, 1, 0);
      check("t8_err_fffe", {16'd0, err_cnt}, 32'h0000FFFE);
      send_beat(16'd1, 1, 0);
      check("t8_err_ffff", {16'd0, err_cnt}, 32'h0000FFFF);
      send_beat(16'd1, 1, 0);
      check("t8_err_hold", {16'd0, err_cnt}, 32'h0000FFFF);
      idle(2);

      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
AXI-Stream sink that terminates a stream master such as a_test_md's origin_inf. It consumes frames under programmable back-pressure and checks each frame's payload against an incrementing pattern and an expected length. It exposes registered frame, beat and error statistics, and sits at the receive end of integration tops as the self-check for pattern generators.

Parameters:
DSIZE, 16, tdata width; must match the connected axi_stream_inf.
LSIZE, 16, width of the per-frame beat counter, exp_len and last_len.
CSIZE, 32, width of frame_cnt and beat_cnt.

Ports:
clock  input  1  single clock; sink_inf.aclk must be driven from the same clock.
rst_n  input  1  asynchronous active-low reset.
sink_inf  axi_stream_inf.slave  DSIZE/USIZE=1  stream input.
- Uses axis_tvalid, axis_tdata, axis_tlast; drives axis_tready.
- axis_tuser and aclken are ignored.
throttle  input  4  number of idle cycles with tready low after each accepted beat; 0 = always ready.
exp_len  input  LSIZE  expected beats per frame; 0 disables the length check.
clr  input  1  synchronous clear of statistics.
frame_cnt  output  CSIZE  frames completed (tlast accepted), wraps.
beat_cnt  output  CSIZE  beats accepted, wraps.
err_cnt  output  16  total errors, saturates at 16'hFFFF.
last_len  output  LSIZE  length of the most recently completed frame.
err_data  output  1  one-cycle pulse on a data mismatch.
err_len  output  1  one-cycle pulse on a length mismatch.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async assert, sync release):
  - tready=0 and FSM=IDLE.
  - All counters, last_len, err_data, err_len and busy are 0.
  - Expected data is 0 and the gap counter is 0.
  - First cycle after release: tready=1.
- A handshake (accept) is tvalid&tready in the same cycle.
- tready is a register and never combinationally depends on tvalid.
- FSM states and transitions:
  - IDLE → RECV: first accept of a frame when tlast=0.
  - IDLE stays IDLE: single-beat frame (accept with tlast=1), processed as a complete frame.
  - RECV stays RECV: accept with tlast=0.
  - RECV → IDLE: accept with tlast=1.
  - busy = (state==RECV).
- Throttle:
  - On each accept, when throttle≠0, tready drops the next cycle and stays low for exactly throttle cycles, then returns to 1.
  - throttle is sampled at the accept.
  - When throttle=0, tready stays 1.
  - The gap is independent of FSM state.
- Data check:
  - Expected value is the beat index within the frame mod 2^DSIZE; it is 0 at frame start.
  - Mismatch → err_data pulses the cycle after the accept.
  - After a mismatch, expected resyncs to received+1.
  - After tlast, expected returns to 0.
- Length check:
  - Beat index counter saturates at 2^LSIZE-1.
  - On tlast accept, the frame length is index+1 (saturated); it is loaded into last_len the next cycle.
  - If exp_len≠0 and length≠exp_len → err_len pulses the next cycle.
- Counters:
  - beat_cnt+1 on every accept.
  - frame_cnt+1 on every tlast accept.
  - err_cnt adds err_data+err_len, giving +0, +1 or +2 in a cycle, saturating at 16'hFFFF.
- Latency: every statistic and pulse is registered, one cycle after the accept.
- clr:
  - Zeroes frame_cnt, beat_cnt and err_cnt, and has priority over an increment in the same cycle; that cycle's event is not counted.
  - Does not affect the FSM, expected data, last_len or tready.
  - Error pulses still fire.
- tvalid high with tready low: no state change, and the data is not sampled.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is not counted.

Test Plan:
- throttle=0, exp_len=4, one frame with data 0,1,2,3 and tlast on the 4th beat → tready constantly 1. Then frame_cnt=1, beat_cnt=4, last_len=4, err_cnt=0, no pulses.
- throttle=2, tvalid held high, 3-beat frame → tready pattern 1,0,0,1,0,0,1. Beats are accepted every 3rd cycle, and busy is high from the cycle after beat 1 until the cycle after beat 3.
- Frame data 0,1,7,8 with exp_len=4 → a single err_data pulse one cycle after beat 3, no err_len, err_cnt=1.
- exp_len=5 with a 3-beat frame whose data is 0,5,2 → err_data pulse after beat 2. After beat 3, err_len pulses with err_data (expected 6 ≠ 2), so err_cnt reaches 3 and last_len=3.
- Single-beat frame (data 0, tlast=1) → FSM never leaves IDLE, frame_cnt+1, last_len=1. clr in the same cycle as that accept → frame_cnt stays 0 and last_len=1.
- Drive rst_n low mid-frame after 2 beats, then release → tready=0 during reset and all outputs 0. A new 2-beat frame 0,1 checks clean and frame_cnt=1.
- Force err_cnt to FFFE, then inject a beat carrying both errors → err_cnt=FFFF and stays there on further errors.
